// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - RS-232 receiver with parity/framing checks and a receive FIFO
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 620,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          out_data,
    output logic                          out_ferr,
    output logic                          out_perr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          busy
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = DATA_BITS + 2;
    localparam logic [BW-1:0] FULL_M1  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_M1  = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t                state;
    logic                  rx_meta, rxs, rxs_prev;
    logic [BW-1:0]         baud;
    logic [2:0]            bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  perr_q;

    logic [EW-1:0]         mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;

    logic                  full_tick, push_req, do_pop, is_full, accept;
    logic [EW-1:0]         entry;

    assign full_tick = (baud == FULL_M1);
    assign push_req  = (state == S_STOP) && full_tick;
    assign entry     = {perr_q, ~rxs, shreg};
    assign do_pop    = out_valid & out_ready;
    assign is_full   = (count == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign accept    = push_req && (!is_full || do_pop);

    assign {out_perr, out_ferr, out_data} = mem[rd_ptr];
    assign out_valid = (count != '0);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            rx_meta  <= rx;
            rxs      <= rx_meta;
            rxs_prev <= rxs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            perr_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    baud    <= '0;
                    bit_cnt <= '0;
                    perr_q  <= 1'b0;
                    if (enable && rxs_prev && !rxs)
                        state <= S_START;
                end
                S_START: begin
                    if (baud == HALF_M1) begin
                        baud  <= '0;
                        state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_DATA: begin
                    if (full_tick) begin
                        baud    <= '0;
                        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == LAST_BIT)
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_PARITY: begin
                    if (full_tick) begin
                        baud   <= '0;
                        perr_q <= (PARITY == 2) ? ~(^shreg ^ rxs) : (^shreg ^ rxs);
                        state  <= S_STOP;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_STOP: begin
                    if (full_tick) begin
                        baud  <= '0;
                        state <= rxs ? S_IDLE : S_WAIT_HIGH;
                    end else begin
                        baud <= baud + BW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push_req && !accept)
                overrun <= 1'b1;
            case ({accept, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    logic       clk, reset, enable, rx, out_ready;
    logic [7:0] out_data;
    logic       out_ferr, out_perr, out_valid, overrun, busy;
    logic [2:0] count;

    int n_cmp = 0;
    int n_err = 0;
    int valid_cycles = 0;
    logic [9:0] popq [$];

    uart_rx_fifo #(
        .CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx),
        .out_data(out_data), .out_ferr(out_ferr), .out_perr(out_perr),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
        .count(count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) valid_cycles++;
        if (out_valid && out_ready) popq.push_back({out_perr, out_ferr, out_data});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // pulse_at >= 0 drives out_ready high only during that cycle of the frame
    task automatic send(input logic [7:0] d, input logic pbit, input logic stop, input int pulse_at);
        logic [10:0] fr;
        fr = {stop, pbit, d, 1'b0};
        for (int b = 0; b < 11; b++) begin
            rx = fr[b];
            for (int k = 0; k < 16; k++) begin
                if (pulse_at >= 0) out_ready = ((b * 16 + k) == pulse_at);
                tick(1);
            end
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b1; enable = 1'b1; rx = 1'b1; out_ready = 1'b0;
        tick(3);
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_data", out_data, 0);
        check("rst_flags", {out_perr, out_ferr}, 0);
        reset = 1'b0;
        tick(2);

        // basic bytes, back-to-back, consumer always ready
        out_ready = 1'b1;
        popq.delete();
        valid_cycles = 0;
        send(8'h55, 1'b0, 1'b1, -1);
        send(8'hA3, 1'b0, 1'b1, -1);
        tick(5);
        check("t1_npops", popq.size(), 2);
        if (popq.size() >= 2) begin
            check("t1_pop0", popq[0], {2'b00, 8'h55});
            check("t1_pop1", popq[1], {2'b00, 8'hA3});
        end
        check("t1_valid_cycles", valid_cycles, 2);
        check("t1_count", count, 0);
        out_ready = 1'b0;

        // glitch rejection
        rx = 1'b0; tick(4);
        rx = 1'b1; tick(2);
        check("t2_busy_start", busy, 1);
        tick(10);
        check("t2_busy_end", busy, 0);
        check("t2_valid", out_valid, 0);
        check("t2_count", count, 0);
        tick(5);

        // parity and framing
        send(8'h07, 1'b1, 1'b1, -1);
        tick(2);
        check("t3a_valid", out_valid, 1);
        check("t3a_data", out_data, 8'h07);
        check("t3a_flags", {out_perr, out_ferr}, 2'b00);
        pop();
        send(8'h07, 1'b0, 1'b1, -1);
        tick(2);
        check("t3b_data", out_data, 8'h07);
        check("t3b_flags", {out_perr, out_ferr}, 2'b10);
        pop();
        send(8'h10, 1'b1, 1'b0, -1);
        tick(40);
        check("t3c_count_low", count, 1);
        check("t3c_data", out_data, 8'h10);
        check("t3c_flags", {out_perr, out_ferr}, 2'b01);
        check("t3c_busy_wait", busy, 1);
        rx = 1'b1; tick(4);
        check("t3c_busy_idle", busy, 0);
        check("t3c_count_high", count, 1);
        pop();
        check("t3_empty", count, 0);
        tick(5);

        // overrun with a 4-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            send(d, ^d, 1'b1, -1);
        end
        tick(2);
        check("t4_count_full", count, 4);
        check("t4_overrun", overrun, 1);
        for (int i = 1; i <= 4; i++) begin
            check("t4_drain_data", out_data, i);
            pop();
        end
        check("t4_count_empty", count, 0);
        check("t4_overrun_sticky", overrun, 1);

        // full FIFO with a pop in the stop-sample cycle
        reset = 1'b1; tick(1); reset = 1'b0;
        check("t5_overrun_cleared", overrun, 0);
        send(8'h11, 1'b0, 1'b1, -1);
        send(8'h22, 1'b0, 1'b1, -1);
        send(8'h33, 1'b0, 1'b1, -1);
        send(8'h44, 1'b0, 1'b1, -1);
        check("t5_count_full", count, 4);
        send(8'h66, 1'b0, 1'b1, 170);
        out_ready = 1'b0;
        tick(2);
        check("t5_count", count, 4);
        check("t5_overrun", overrun, 0);
        check("t5_head", out_data, 8'h22);
        pop(); pop(); pop();
        check("t5_last", out_data, 8'h66);
        check("t5_last_flags", {out_perr, out_ferr}, 2'b00);
        pop();
        check("t5_empty", count, 0);

        // reset during data bit 3 with two bytes queued
        send(8'h5A, 1'b0, 1'b1, -1);
        send(8'hC3, 1'b0, 1'b1, -1);
        check("t6_queued", count, 2);
        d = 8'h99;
        rx = 1'b0; tick(16);
        for (int i = 0; i < 3; i++) begin
            rx = d[i]; tick(16);
        end
        rx = d[3]; tick(6);
        check("t6_busy_before", busy, 1);
        reset = 1'b1; tick(1); reset = 1'b0;
        check("t6_count", count, 0);
        check("t6_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        rx = 1'b1; tick(20);
        send(8'h3C, 1'b0, 1'b1, -1);
        tick(2);
        check("t6_rx_count", count, 1);
        check("t6_rx_data", out_data, 8'h3C);
        check("t6_rx_flags", {out_perr, out_ferr}, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised RS-232 receiver with an on-chip receive FIFO and per-byte error flags. It is the next generation of the `i232c` decoder. It adds configurable data width, parity and FIFO depth, replaces the one-cycle `changed` strobe with a valid/ready handshake, and reports framing, parity and overrun errors. It sits between the board `RS_RX` pin and the core's I/O unit. Benches also instantiate it as a serial-output checker on `RS_TX`.

## Interface
Parameters:
- `CLKS_PER_BIT`, 620, clock cycles per bit period; must be ≥ 4 (620 ≈ 115200 baud at 14 ns clock).
- `DATA_BITS`, 8, data bits per frame; 5–8.
- `PARITY`, 0, parity mode: 0 none, 1 even, 2 odd.
- `FIFO_DEPTH`, 16, FIFO entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  when low, no new frame is started.
- `rx`  in  1  asynchronous serial input; idle high.
- `out_data`  out  DATA_BITS  head-of-FIFO data, LSB = first received bit.
- `out_ferr`  out  1  head entry had stop bit = 0.
- `out_perr`  out  1  head entry failed the parity check; always 0 when `PARITY`=0.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head entry when `out_valid & out_ready`.
- `overrun`  out  1  sticky; a completed frame was dropped because the FIFO was full.
- `count`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `busy`  out  1  receiver FSM is not in IDLE.

## Operation
- **Input synchroniser:** `rx` passes through a 2-flop synchroniser; `rxs` is its output. Both flops reset to 1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. A bit counter and a baud counter (0..CLKS_PER_BIT-1) drive the sequencing.
- **IDLE:** if `enable` and `rxs` falls (1→0 versus the previous sample), go to START and load the baud counter for a half-bit wait.
- **START:** at half-bit, re-sample `rxs`.
  - 0: go to DATA and reload the full-bit wait.
  - 1: treat as a glitch and return to IDLE; nothing is pushed.
- **DATA:** sample `rxs` every full bit, shifting in LSB first. After DATA_BITS samples, go to PARITY if `PARITY`≠0, else to STOP.
- **PARITY:** sample one bit.
  - Parity error if the XOR of data and parity bit is 1 (even mode) or 0 (odd mode).
- **STOP:** sample the stop bit and attempt the FIFO push in the same cycle.
  - Stop bit 1: go to IDLE, so a back-to-back start edge is detected immediately.
  - Stop bit 0: go to WAIT_HIGH.
- **WAIT_HIGH:** stay until `rxs`=1, then go to IDLE.
- **FIFO entry:** {perr, ferr, data}. A frame with an error is still pushed, with its flags set.
- **FIFO full at push:** the entry is dropped, `overrun` is set, and FIFO contents are unchanged.
- **Pop:** on `out_valid & out_ready`. A push and a pop in the same cycle are both performed; `count` is unchanged.
- **Simultaneous push and pop when full:** the push succeeds, because the pop frees the slot in the same cycle; `overrun` is not set.
- **Pointers:** wrap modulo FIFO_DEPTH. `count` distinguishes full from empty.
- **`enable`:** only gates the IDLE→START transition. A frame already in progress completes.

## Timing
- **Reset values:**
  - FSM = IDLE, synchroniser = 1, FIFO pointers and `count` = 0.
  - `out_valid`=0, `overrun`=0, `busy`=0.
  - `out_data`, `out_ferr`, `out_perr` = 0.
- **Reset mid-frame:** aborts the frame, flushes the FIFO and clears `overrun` in the same cycle.
- **Sample timing:** let t be the cycle in which the FSM registers the falling edge of `rxs` (this is 2 cycles after the pin edge).
  - Start check: t + CLKS_PER_BIT/2 (integer division).
  - Data bit i: t + CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT.
  - Parity, then stop: each follows one CLKS_PER_BIT later.
- **Push to output:** the push registers at the stop-sample edge. `out_valid` and the entry are visible the following cycle when the FIFO was empty. Latency from pin stop-bit midpoint to `out_valid` ≈ 3 cycles.
- **Output stability:** `out_data` and the flags are registered and stable while `out_valid`=1 and no pop occurs.
- **Back-to-back pops:** allowed every cycle.
- **`busy`:** 1 from the cycle after IDLE→START until the FSM returns to IDLE.

## Test plan
Use `CLKS_PER_BIT`=16 for the directed tests below.
1. **Basic byte:** `DATA_BITS`=8, no parity. Send 0x55 then 0xA3 back-to-back, one stop bit, with `out_ready`=1 → two pops with data 0x55 and 0xA3, ferr=0 and perr=0; `out_valid` high 1 cycle each.
2. **Glitch rejection:** 4-cycle low pulse on `rx` → FSM returns to IDLE after the half-bit check; `out_valid` stays 0; `busy` drops.
3. **Parity and framing:** `PARITY`=1.
   - Send 0x07 with parity bit 1 → perr=0.
   - Send 0x07 with parity bit 0 → perr=1.
   - Send 0x10 with stop=0, then hold `rx` low 40 cycles → ferr=1; no further entries until `rx` returns high.
4. **Overrun:** `FIFO_DEPTH`=4, `out_ready`=0. Send 5 bytes 0x01–0x05 → `count`=4 and `overrun`=1. Then drain → 0x01, 0x02, 0x03, 0x04; `overrun` remains 1.
5. **Full with simultaneous pop:** FIFO full, pulse `out_ready` exactly in the stop-sample cycle of byte 0x66 → `count` stays 4, `overrun`=0, 0x66 is the last entry.
6. **Reset mid-frame:** assert `reset` during DATA bit 3 with 2 bytes queued → next cycle `count`=0, `out_valid`=0, `busy`=0. A subsequent 0x3C is received correctly.
